// File: rtl/fwd_stall_unit.sv
// Operand forwarding and load-use interlock beside the ID stage of the 5-stage pipeline.
// Define FWD_WB_EN to make the WB stage a forwarding source (sel=3) at lowest priority.
module fwd_stall_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_reg_id_i,
    input  logic [NUM_SRC-1:0]           src_used_i,
    input  logic                         reg_write_ex_i,
    input  logic                         mem_read_ex_i,
    input  logic [REG_ADDR_W-1:0]        write_reg_ex_i,
    input  logic [DATA_W-1:0]            alu_result_ex_i,
    input  logic                         reg_write_mem_i,
    input  logic                         mem_read_mem_i,
    input  logic [REG_ADDR_W-1:0]        write_reg_mem_i,
    input  logic [DATA_W-1:0]            alu_result_mem_i,
    input  logic [DATA_W-1:0]            load_data_mem_i,
    input  logic                         reg_write_wb_i,
    input  logic [REG_ADDR_W-1:0]        write_reg_wb_i,
    input  logic [DATA_W-1:0]            result_wb_i,
    output logic [2*NUM_SRC-1:0]         fwd_sel_o,
    output logic [NUM_SRC*DATA_W-1:0]    fwd_data_o,
    output logic                         stall_o,
    output logic [CNT_W-1:0]             stall_count_o
);

    localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

    typedef enum logic {IDLE, STALL} state_t;

    state_t            state, stateNext;
    logic [CW-1:0]     cnt, cntNext;
    logic [CNT_W-1:0]  stallCount;
    logic [NUM_SRC-1:0] loadUse;
    logic              hazard;
    logic              stall;

`ifndef FWD_WB_EN
    // WB is not a source in this build; the register file handles write-before-read.
    logic unusedWb;
    assign unusedWb = ^{reg_write_wb_i, write_reg_wb_i, result_wb_i};
`endif

    for (genvar k = 0; k < NUM_SRC; k++) begin : gSrc
        logic [REG_ADDR_W-1:0] srcReg;
        logic                  exHit, memHit, wbHit;
        logic [1:0]            sel;
        logic [DATA_W-1:0]     data;

        assign srcReg = src_reg_id_i[k*REG_ADDR_W +: REG_ADDR_W];
        assign exHit  = src_used_i[k] & reg_write_ex_i & (write_reg_ex_i == srcReg)
                        & (write_reg_ex_i != '0);
        assign memHit = src_used_i[k] & reg_write_mem_i & (write_reg_mem_i == srcReg)
                        & (write_reg_mem_i != '0);
`ifdef FWD_WB_EN
        assign wbHit  = src_used_i[k] & reg_write_wb_i & (write_reg_wb_i == srcReg)
                        & (write_reg_wb_i != '0);
`else
        assign wbHit  = 1'b0;
`endif
        assign loadUse[k] = exHit & mem_read_ex_i;

        // A load in EX cannot forward yet, so the source falls through to older stages.
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        always_comb begin
            sel  = 2'd0;
            data = '0;
            if (rst) begin
                sel  = 2'd0;
            end else if (exHit && !mem_read_ex_i) begin
                sel  = 2'd1;
                data = alu_result_ex_i;
            end else if (memHit) begin
                sel  = 2'd2;
                data = mem_read_mem_i ? load_data_mem_i : alu_result_mem_i;
            end else if (wbHit) begin
                sel  = 2'd3;
                data = result_wb_i;
            end
        end

        assign fwd_sel_o[2*k +: 2]           = sel;
        assign fwd_data_o[k*DATA_W +: DATA_W] = data;
    end

    assign hazard = |loadUse;

    // The detection cycle is the first stall cycle; STALL covers the remaining LOAD_STALL-1.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stall     = 1'b0;
        if (flush_i) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        stall = 1'b1;
                        if (LOAD_STALL > 1) begin
                            stateNext = STALL;
                            cntNext   = CW'(LOAD_STALL - 1);
                        end
                    end
                end
                STALL: begin
                    stall   = 1'b1;
                    cntNext = cnt - CW'(1);
                    if (cnt == CW'(1)) stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    assign stall_o       = stall & ~rst;
    assign stall_count_o = stallCount;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            stallCount <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (stall && (stallCount != '1)) stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench for fwd_stall_unit: table of combinational forwarding vectors plus
// stall/flush/reset/saturation sequences on a LOAD_STALL=2 and a LOAD_STALL=1 instance.
module tb_fwd_stall_unit;

`ifdef FWD_WB_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [9:0]  src_reg_id_i;
    logic [1:0]  src_used_i;
    logic        reg_write_ex_i, mem_read_ex_i;
    logic [4:0]  write_reg_ex_i;
    logic [31:0] alu_result_ex_i;
    logic        reg_write_mem_i, mem_read_mem_i;
    logic [4:0]  write_reg_mem_i;
    logic [31:0] alu_result_mem_i, load_data_mem_i;
    logic        reg_write_wb_i;
    logic [4:0]  write_reg_wb_i;
    logic [31:0] result_wb_i;

    logic [3:0]  fwdSelA, fwdSelB;
    logic [63:0] fwdDataA, fwdDataB;
    logic        stallA, stallB;
    logic [3:0]  cntA;
    logic [15:0] cntB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_stall_unit #(.DATA_W(32), .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_STALL(2), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .src_reg_id_i(src_reg_id_i), .src_used_i(src_used_i),
        .reg_write_ex_i(reg_write_ex_i), .mem_read_ex_i(mem_read_ex_i),
        .write_reg_ex_i(write_reg_ex_i), .alu_result_ex_i(alu_result_ex_i),
        .reg_write_mem_i(reg_write_mem_i), .mem_read_mem_i(mem_read_mem_i),
        .write_reg_mem_i(write_reg_mem_i), .alu_result_mem_i(alu_result_mem_i),
        .load_data_mem_i(load_data_mem_i),
        .reg_write_wb_i(reg_write_wb_i), .write_reg_wb_i(write_reg_wb_i),
        .result_wb_i(result_wb_i),
        .fwd_sel_o(fwdSelA), .fwd_data_o(fwdDataA), .stall_o(stallA), .stall_count_o(cntA)
    );

    fwd_stall_unit #(.DATA_W(32), .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_STALL(1), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .src_reg_id_i(src_reg_id_i), .src_used_i(src_used_i),
        .reg_write_ex_i(reg_write_ex_i), .mem_read_ex_i(mem_read_ex_i),
        .write_reg_ex_i(write_reg_ex_i), .alu_result_ex_i(alu_result_ex_i),
        .reg_write_mem_i(reg_write_mem_i), .mem_read_mem_i(mem_read_mem_i),
        .write_reg_mem_i(write_reg_mem_i), .alu_result_mem_i(alu_result_mem_i),
        .load_data_mem_i(load_data_mem_i),
        .reg_write_wb_i(reg_write_wb_i), .write_reg_wb_i(write_reg_wb_i),
        .result_wb_i(result_wb_i),
        .fwd_sel_o(fwdSelB), .fwd_data_o(fwdDataB), .stall_o(stallB), .stall_count_o(cntB)
    );

    typedef struct {
        logic [4:0]  s0, s1;
        logic [1:0]  used;
        logic        wEx, ldEx;
        logic [4:0]  rEx;
        logic [31:0] aEx;
        logic        wMem, ldMem;
        logic [4:0]  rMem;
        logic [31:0] aMem, lMem;
        logic        wWb;
        logic [4:0]  rWb;
        logic [31:0] dWb;
        logic [1:0]  eSel0, eSel1;
        logic [31:0] eD0, eD1;
        logic        eStall;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush_i = 1'b0;
        src_reg_id_i = '0; src_used_i = '0;
        reg_write_ex_i = 0; mem_read_ex_i = 0; write_reg_ex_i = '0; alu_result_ex_i = '0;
        reg_write_mem_i = 0; mem_read_mem_i = 0; write_reg_mem_i = '0;
        alu_result_mem_i = '0; load_data_mem_i = '0;
        reg_write_wb_i = 0; write_reg_wb_i = '0; result_wb_i = '0;
    endtask

    task automatic hazardIn();
        quiet();
        src_reg_id_i = {5'd0, 5'd5};
        src_used_i = 2'b01;
        reg_write_ex_i = 1; mem_read_ex_i = 1; write_reg_ex_i = 5'd5;
    endtask

    task automatic doReset();
        rst = 1'b1;
        quiet();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic setVec(input vec_t v);
        flush_i = 1'b0;
        src_reg_id_i = {v.s1, v.s0};
        src_used_i = v.used;
        reg_write_ex_i = v.wEx; mem_read_ex_i = v.ldEx;
        write_reg_ex_i = v.rEx; alu_result_ex_i = v.aEx;
        reg_write_mem_i = v.wMem; mem_read_mem_i = v.ldMem;
        write_reg_mem_i = v.rMem; alu_result_mem_i = v.aMem; load_data_mem_i = v.lMem;
        reg_write_wb_i = v.wWb; write_reg_wb_i = v.rWb; result_wb_i = v.dWb;
    endtask

    // Reset gating: inputs that would forward and stall, rst held high.
    task automatic resetCheck(input string tag);
        hazardIn();
        reg_write_mem_i = 1; write_reg_mem_i = 5'd5; alu_result_mem_i = 32'h99;
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_sel"}, {28'd0, fwdSelA}, 32'd0);
        check({tag, "_data0"}, fwdDataA[31:0], 32'd0);
        check({tag, "_stallA"}, {31'd0, stallA}, 32'd0);
        check({tag, "_stallB"}, {31'd0, stallB}, 32'd0);
        tick();
        @(negedge clk);
        check({tag, "_cntA"}, {28'd0, cntA}, 32'd0);
        check({tag, "_cntB"}, {16'd0, cntB}, 32'd0);
        tick();
        rst = 1'b0;
        quiet();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          s0    s1    used  wEx ldEx rEx    aEx       wMem ldMem rMem   aMem          lMem          wWb rWb    dWb       eSel0 eSel1 eD0 eD1 eStall
        vecs[0]  = '{5'd3, 5'd0, 2'b11, 1, 0, 5'd3, 32'h11, 1, 0, 5'd3, 32'h22, 32'h0, 0, 5'd0, 32'h0,
                     2'd1, 2'd0, 32'h11, 32'h0, 0};
        vecs[1]  = '{5'd4, 5'd0, 2'b11, 1, 0, 5'd0, 32'h55, 1, 0, 5'd0, 32'h66, 32'h0, 0, 5'd0, 32'h0,
                     2'd0, 2'd0, 32'h0, 32'h0, 0};
        vecs[2]  = '{5'd5, 5'd0, 2'b01, 1, 1, 5'd5, 32'h33, 1, 0, 5'd5, 32'h77, 32'h0, 0, 5'd0, 32'h0,
                     2'd2, 2'd0, 32'h77, 32'h0, 1};
        vecs[3]  = '{5'd5, 5'd5, 2'b00, 1, 1, 5'd5, 32'h33, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0,
                     2'd0, 2'd0, 32'h0, 32'h0, 0};
        vecs[4]  = '{5'd7, 5'd0, 2'b01, 0, 0, 5'd0, 32'h0, 1, 1, 5'd7, 32'h12345678, 32'hDEADBEEF,
                     1, 5'd7, 32'h1, 2'd2, 2'd0, 32'hDEADBEEF, 32'h0, 0};
        vecs[5]  = '{5'd0, 5'd7, 2'b10, 0, 0, 5'd0, 32'h0, 1, 0, 5'd8, 32'h44, 32'h0, 1, 5'd7, 32'h1,
                     2'd0, WB_ON ? 2'd3 : 2'd0, 32'h0, WB_ON ? 32'h1 : 32'h0, 0};
        vecs[6]  = '{5'd10, 5'd9, 2'b11, 1, 0, 5'd9, 32'hA5, 1, 0, 5'd10, 32'hB6, 32'h0, 0, 5'd0, 32'h0,
                     2'd2, 2'd1, 32'hB6, 32'hA5, 0};
        vecs[7]  = '{5'd0, 5'd0, 2'b11, 1, 1, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0,
                     2'd0, 2'd0, 32'h0, 32'h0, 0};
        vecs[8]  = '{5'd6, 5'd6, 2'b10, 1, 1, 5'd6, 32'h88, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0,
                     2'd0, 2'd0, 32'h0, 32'h0, 1};
        vecs[9]  = '{5'd11, 5'd0, 2'b01, 0, 0, 5'd11, 32'hEE, 1, 1, 5'd11, 32'hF0, 32'hF1, 0, 5'd0, 32'h0,
                     2'd2, 2'd0, 32'hF1, 32'h0, 0};
        vecs[10] = '{5'd12, 5'd0, 2'b01, 1, 1, 5'd12, 32'h9, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd12, 32'hCAFE,
                     WB_ON ? 2'd3 : 2'd0, 2'd0, WB_ON ? 32'hCAFE : 32'h0, 32'h0, 1};

        rst = 1'b1;
        quiet();
        tick();
        resetCheck("rst0");
        doReset();

        // Combinational forwarding table; one quiet cycle drains any stall it starts.
        for (int i = 0; i < NV; i++) begin
            setVec(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_sel0", i), {30'd0, fwdSelA[1:0]}, {30'd0, vecs[i].eSel0});
            check($sformatf("v%0d_sel1", i), {30'd0, fwdSelA[3:2]}, {30'd0, vecs[i].eSel1});
            check($sformatf("v%0d_data0", i), fwdDataA[31:0], vecs[i].eD0);
            check($sformatf("v%0d_data1", i), fwdDataA[63:32], vecs[i].eD1);
            check($sformatf("v%0d_stallA", i), {31'd0, stallA}, {31'd0, vecs[i].eStall});
            check($sformatf("v%0d_stallB", i), {31'd0, stallB}, {31'd0, vecs[i].eStall});
            tick();
            quiet();
            tick();
        end

        // Single load-use stall: 2 cycles on A, 1 on B.
        doReset();
        hazardIn();
        @(negedge clk);
        check("ls_c1_stallA", {31'd0, stallA}, 32'd1);
        check("ls_c1_stallB", {31'd0, stallB}, 32'd1);
        tick();
        quiet();
        @(negedge clk);
        check("ls_c2_stallA", {31'd0, stallA}, 32'd1);
        check("ls_c2_stallB", {31'd0, stallB}, 32'd0);
        tick();
        @(negedge clk);
        check("ls_c3_stallA", {31'd0, stallA}, 32'd0);
        check("ls_cntA", {28'd0, cntA}, 32'd2);
        check("ls_cntB", {16'd0, cntB}, 32'd1);
        tick();

        // Hazard held: back-to-back stalls with no gap.
        hazardIn();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b_%0d_stallA", i), {31'd0, stallA}, 32'd1);
            check($sformatf("b2b_%0d_stallB", i), {31'd0, stallB}, 32'd1);
            tick();
        end
        quiet();
        @(negedge clk);
        check("b2b_end_stallA", {31'd0, stallA}, 32'd0);
        check("b2b_cntA", {28'd0, cntA}, 32'd6);
        check("b2b_cntB", {16'd0, cntB}, 32'd5);
        tick();

        // Flush beats a simultaneous hazard, and aborts a stall in progress.
        doReset();
        hazardIn();
        flush_i = 1'b1;
        @(negedge clk);
        check("fl_det_stallA", {31'd0, stallA}, 32'd0);
        check("fl_det_stallB", {31'd0, stallB}, 32'd0);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("fl_after_stallA", {31'd0, stallA}, 32'd1);
        tick();
        quiet();
        flush_i = 1'b1;
        @(negedge clk);
        check("fl_mid_stallA", {31'd0, stallA}, 32'd0);
        tick();
        quiet();
        @(negedge clk);
        check("fl_idle_stallA", {31'd0, stallA}, 32'd0);
        check("fl_cntA", {28'd0, cntA}, 32'd1);
        tick();
        hazardIn();
        @(negedge clk);
        check("fl_fresh_c1", {31'd0, stallA}, 32'd1);
        tick();
        quiet();
        @(negedge clk);
        check("fl_fresh_c2", {31'd0, stallA}, 32'd1);
        tick();
        @(negedge clk);
        check("fl_fresh_c3", {31'd0, stallA}, 32'd0);
        check("fl_fresh_cntA", {28'd0, cntA}, 32'd3);
        tick();

        // Reset in the middle of a stall ends it.
        hazardIn();
        @(negedge clk);
        check("mr_c1_stallA", {31'd0, stallA}, 32'd1);
        tick();
        quiet();
        rst = 1'b1;
        @(negedge clk);
        check("mr_rst_stallA", {31'd0, stallA}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_after_stallA", {31'd0, stallA}, 32'd0);
        check("mr_cntA", {28'd0, cntA}, 32'd0);
        tick();

        // Stall counter saturation on the 4-bit instance.
        doReset();
        hazardIn();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat_cntA_14", {28'd0, cntA}, 32'hE);
        end
        @(negedge clk);
        check("sat_cntA_20", {28'd0, cntA}, 32'hF);
        check("sat_cntB_20", {16'd0, cntB}, 32'd20);
        tick();
        resetCheck("rst1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_stall_unit.md
# fwd_stall_unit

Parametrised operand-forwarding and load-use interlock unit for the 5-stage MIPS pipeline, sitting beside the ID stage. For each of NUM_SRC source operands it picks the youngest in-flight producer (EX, MEM, optionally WB) or falls back to the register file. A small FSM stalls ID for a configurable number of cycles on a load-use hazard, and a saturating counter reports total stall cycles.

## Interface
Parameters:
- DATA_W, 32, operand width
- REG_ADDR_W, 5, register specifier width
- NUM_SRC, 2, number of source operands checked per ID instruction
- LOAD_STALL, 1, load-use stall length in cycles (≥1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; aborts an in-progress stall
- src_reg_id_i  in  NUM_SRC*REG_ADDR_W  ID source register specifiers, source k at bits [k*REG_ADDR_W +: REG_ADDR_W]
- src_used_i  in  NUM_SRC  source k actually read by the ID instruction
- reg_write_ex_i, mem_read_ex_i  in  1 each  EX instruction writes a register / is a load
- write_reg_ex_i  in  REG_ADDR_W  EX destination
- alu_result_ex_i  in  DATA_W  EX result
- reg_write_mem_i, mem_read_mem_i  in  1 each  MEM writes / is a load
- write_reg_mem_i  in  REG_ADDR_W  MEM destination
- alu_result_mem_i, load_data_mem_i  in  DATA_W each  MEM ALU result / load data
- reg_write_wb_i  in  1  WB writes
- write_reg_wb_i  in  REG_ADDR_W  WB destination
- result_wb_i  in  DATA_W  WB write-back data
- fwd_sel_o  out  2*NUM_SRC  per source: 0 regfile, 1 EX, 2 MEM, 3 WB
- fwd_data_o  out  NUM_SRC*DATA_W  forwarded value (0 when sel=0)
- stall_o  out  1  hold PC and IF/ID, inject bubble into EX
- stall_count_o  out  CNT_W  saturating count of stall cycles

## Operation
- Match of source k against stage S: src_used_i[k] & reg_write_S & write_reg_S==src & write_reg_S!=0. Register 0 never forwards or stalls.
- Priority EX > MEM > WB; first match wins.
- EX match, non-load: sel=1, data=alu_result_ex_i.
- EX match, load (mem_read_ex_i): load-use hazard; no EX forward; sel/data fall to the next match in priority order.
- MEM match: sel=2, data=load_data_mem_i if mem_read_mem_i else alu_result_mem_i.
- WB match: sel=3, data=result_wb_i (FWD_WB_EN only).
- FSM states IDLE, STALL; 0..LOAD_STALL-1 down-counter cnt.
  - IDLE: hazard on any source -> stall_o=1 this cycle; if LOAD_STALL>1 go STALL, cnt=LOAD_STALL-1, else stay IDLE.
  - STALL: stall_o=1, hazard detection ignored; cnt decrements; cnt==1 -> IDLE next cycle.
  - flush_i in either state: stall_o=0 that cycle, next state IDLE, cnt=0. Flush wins over simultaneous hazard.
- stall_count_o increments on every cycle with stall_o=1; holds at all ones.

## Timing
- Forwarding is combinational, zero latency from inputs to fwd_sel_o/fwd_data_o.
- stall_o asserted in the detection cycle; total stall = exactly LOAD_STALL consecutive cycles absent flush.
- Back-to-back hazards: a new hazard seen in IDLE the cycle after a stall ends starts a fresh stall.
- While rst=1: stall_o=0, fwd_sel_o=0, fwd_data_o=0; state IDLE, cnt=0, stall_count_o=0 after the edge. Reset mid-stall terminates it.

## Configuration
- FWD_WB_EN defined: WB stage is a forwarding source (sel=3) at lowest priority.
- Undefined: WB inputs ignored; sel value 3 never produced; register file must be write-before-read.

## Test plan
- src0=r3 used, EX writes r3 (non-load, alu=0x11), MEM writes r3 (alu=0x22) -> sel0=1, data0=0x11, stall_o=0.
- src1=r0 used, EX writes r0 -> sel1=0, data1=0, no stall.
- LOAD_STALL=2, EX load to r5, src0=r5 used -> stall_o=1 for exactly 2 cycles, stall_count_o=2, then IDLE.
- EX load to r5 but src_used_i=0 -> stall_o=0; flush_i on 1st stall cycle -> stall_o=0 immediately, IDLE next.
- MEM load r7 data 0xDEADBEEF, WB r7 0x1 -> sel=2, data 0xDEADBEEF; MEM no match, WB r7 -> sel=3/0x1 with FWD_WB_EN, sel=0 without.
- CNT_W=4, force 20 stall cycles -> stall_count_o saturates 0xF; rst -> all outputs 0.
